// File: rtl/conv_pkg.sv
// Shared constants, product-array type and tap extraction for the 4x4 convolution MAC.
package conv_pkg;
    localparam int N_TAPS = 16;
    localparam int DW     = 8;
    localparam int PROD_W = 16;
    localparam int PSUM_W = 18;
    localparam int TREE_W = 20;

    typedef logic signed [PROD_W-1:0] prod_arr_t [N_TAPS];

    // Element k = 4*row + col sits in the top-most byte for k = 0.
    function automatic logic signed [DW-1:0] tap(input logic [N_TAPS*DW-1:0] vec, input int k);
        return $signed(vec[N_TAPS*DW-1-DW*k -: DW]);
    endfunction
endpackage

// File: rtl/mac_add4.sv
// Registered signed 4-input adder; operands are sign-extended to OUT_W and the sum loads when en_i is high.
module mac_add4
    import conv_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic signed [IN_W-1:0]  a_i,
    input  logic signed [IN_W-1:0]  b_i,
    input  logic signed [IN_W-1:0]  c_i,
    input  logic signed [IN_W-1:0]  d_i,
    output logic signed [OUT_W-1:0] sum_o
);
    logic signed [OUT_W-1:0] sum_q;
    logic signed [OUT_W-1:0] sum_d;

    always_comb begin
        sum_d = OUT_W'(a_i) + OUT_W'(b_i) + OUT_W'(c_i) + OUT_W'(d_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (en_i) begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;
endmodule

// File: rtl/conv_mac4x4.sv
// 4x4 signed multiply-accumulate over channel beats with a valid/ready result port.
// Build option: define CONV_MAC_RELU_EN to clamp negative group results to zero.
module conv_mac4x4
    import conv_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_TAPS*DW-1:0]   filter_in,
    input  logic [N_TAPS*DW-1:0]   window_in,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [ACC_W-1:0]       sum_out,
    output logic                   out_valid,
    input  logic                   out_ready
);
    logic stall;
    logic adv;

    prod_arr_t prod_d;
    prod_arr_t prod_q;
    logic      v1_q, l1_q;
    logic      v2_q, l2_q;

    logic signed [PSUM_W-1:0] psum_q [4];

    logic                    s3_fire;
    logic                    s3_last;
    logic                    clr_q;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_p01;
    logic signed [ACC_W-1:0] acc_run_q;
    logic signed [ACC_W-1:0] res_view;

    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] hold_q, hold_d;

    assign stall    = out_valid_q && !out_ready;
    assign adv      = !stall;
    assign in_ready = !stall;

    always_comb begin
        for (int k = 0; k < N_TAPS; k++) begin
            prod_d[k] = PROD_W'(tap(filter_in, k)) * PROD_W'(tap(window_in, k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                prod_q[k] <= '0;
            end
            v1_q <= 1'b0;
            l1_q <= 1'b0;
            v2_q <= 1'b0;
            l2_q <= 1'b0;
        end else if (adv) begin
            prod_q <= prod_d;
            v1_q   <= in_valid;
            l1_q   <= in_valid && in_last;
            v2_q   <= v1_q;
            l2_q   <= l1_q;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_s2
        mac_add4 #(.IN_W(PROD_W), .OUT_W(PSUM_W)) u_s2 (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (adv),
            .a_i   (prod_q[4*g]),
            .b_i   (prod_q[4*g+1]),
            .c_i   (prod_q[4*g+2]),
            .d_i   (prod_q[4*g+3]),
            .sum_o (psum_q[g])
        );
    end

    // The S3 adder register is the accumulator itself; after a last beat it
    // still holds the group result, and clr_q makes the next group start at 0.
    assign s3_fire  = adv && v2_q;
    assign s3_last  = s3_fire && l2_q;
    assign acc_base = clr_q ? '0 : acc_run_q;
    assign acc_p01  = ACC_W'(psum_q[0]) + ACC_W'(psum_q[1]);

    mac_add4 #(.IN_W(ACC_W), .OUT_W(ACC_W)) u_s3 (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (s3_fire),
        .a_i   (acc_base),
        .b_i   (acc_p01),
        .c_i   (ACC_W'(psum_q[2])),
        .d_i   (ACC_W'(psum_q[3])),
        .sum_o (acc_run_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_q <= 1'b0;
        end else if (s3_fire) begin
            clr_q <= l2_q;
        end
    end

`ifdef CONV_MAC_RELU_EN
    assign res_view = acc_run_q[ACC_W-1] ? '0 : acc_run_q;
`else
    assign res_view = acc_run_q;
`endif

    // Once a result is consumed its value is parked in hold_q so sum_out
    // does not follow the next group's running sum.
    always_comb begin
        out_valid_d = out_valid_q;
        hold_d      = hold_q;
        if (out_valid_q && out_ready && !s3_last) begin
            out_valid_d = 1'b0;
            hold_d      = res_view;
        end
        if (s3_last) begin
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            hold_q      <= hold_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum_out   = out_valid_q ? res_view : hold_q;
endmodule

// File: doc/conv_mac4x4.md
Name: conv_mac4x4

Overview:
- Downstream consumer of the 4x4 filter buffer.
- Each beat takes the buffer's 128-bit packed filter and a matching 128-bit packed 4x4 input window.
- Forms 16 signed 8x8 products, reduces them in a pipelined adder tree, and accumulates across beats (channels) until a beat flagged last.
- Presents the accumulated sum on a valid/ready output to the feature-map writer.

Parameters:
- DW, 8, element width in bits (signed two's complement).
- ACC_W, 24, accumulator and output width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- filter_in  input  128  packed filter; element [r][c] (index k=4r+c) at bits [127-8k -: 8]
- window_in  input  128  packed window, same packing as filter_in
- in_valid  input  1  beat present
- in_last  input  1  final beat of accumulation group; qualified by in_valid
- in_ready  output  1  block accepts a beat this cycle
- sum_out  output  ACC_W  accumulated result
- out_valid  output  1  sum_out valid
- out_ready  input  1  consumer accepts sum_out

Behaviour:
- Reset (async, rst_n low):
  - out_valid=0, sum_out=0, acc=0.
  - All pipeline valid/last flags 0.
  - in_ready=1 once rst_n is released.
  - Asserting rst_n mid-group discards the partial accumulation and any in-flight beats.
- Accept and stall:
  - A beat is accepted when in_valid && in_ready at a rising edge.
  - stall = out_valid && !out_ready; in_ready = !stall.
  - While stall is high, every pipeline register, flag and acc holds its value.
- Pipeline, with acceptance at edge T:
  - S1 (edge T): register 16 signed products, 16 bits each, plus valid and last.
  - S2 (edge T+1): four 4-input partial sums (18 bits), plus valid and last.
  - S3 (edge T+2): tree_sum = sum of the four partials (20 bits signed); acc_next = acc + sign-extended tree_sum, wrapping modulo 2^ACC_W with no saturation.
  - S3, last=0: acc <= acc_next.
  - S3, last=1: sum_out <= acc_next, out_valid <= 1, acc <= 0.
  - Latency: out_valid is high in the cycle after edge T+2 for the last beat accepted at T, i.e. 3 edges from acceptance.
- Output handshake:
  - sum_out stays stable while out_valid && !out_ready.
  - On out_valid && out_ready with no new S3 result, out_valid <= 0.
  - If an S3 last-result coincides with out_ready=1, the new sum loads and out_valid stays 1. No result is lost or duplicated.
- Boundary cases:
  - A single-beat group (in_last on the first beat) is legal.
  - Back-to-back groups at one beat per cycle are supported at full throughput while out_ready=1.
  - in_last is ignored when in_valid=0.
  - Beats with in_valid=0 leave acc untouched.

Optional Feature:
- Macro CONV_MAC_RELU_EN.
- Defined: at S3 last, if acc_next is negative, sum_out <= 0; otherwise sum_out <= acc_next. acc is still cleared.
- Undefined: sum_out is the raw signed wrapped acc_next.
- Latency is unchanged either way.

Decomposition:
- Package conv_pkg holds:
  - constants N_TAPS=16, DW=8, PROD_W=16, PSUM_W=18, TREE_W=20;
  - typedef for the signed product array;
  - function tap(vec,k) returning element k per the packing above.
- One sub-module, mac_add4: registered signed 4-input adder with a parameterised width and an enable (stall) input.
  - Four instances in S2, one in S3.

Test Plan:
- Unity:
  - Stimulus: filter_in = window_in = all bytes 0x01, in_last=1, out_ready=1.
  - Response: out_valid 3 edges later, sum_out=0x000010.
- Signed extreme:
  - Stimulus: filter all 0x7F, window all 0x80, in_last=1.
  - Response: sum_out=0xFC0800 (-260096).
  - With CONV_MAC_RELU_EN defined, sum_out=0x000000.
- Accumulation:
  - Stimulus: 3 consecutive beats, filter all 0x02, window all 0x03, in_last on the third beat.
  - Response: exactly one out_valid pulse, sum_out=288 (0x000120).
- Backpressure:
  - Stimulus: stream single-beat groups with sums 16, 32, 48, 64, 80 while out_ready is held low for 5 cycles after the first result.
  - Response: in_ready=0 during the stall, sum_out held at 16, then results 16,32,48,64,80 in order with none lost.
- Reset mid-group:
  - Stimulus: 2 non-last beats of all 0x05, pulse rst_n low asynchronously, then one unity beat with in_last.
  - Response: sum_out=16; out_valid and sum_out read 0 during reset.
- Wrap:
  - Stimulus: 64 beats of filter all 0x7F, window all 0x7F, in_last on beat 64.
  - Response: sum_out = (64*258064) mod 2^24 = 0xFC0400; no saturation.
